// File: rtl/accel_lock_arbiter_pkg.sv
// Shared types and helpers for the accelerator lock arbiter.
//   lock_state_e : lock FSM states (IDLE, OWNED, RST)
//   OWNER_NONE   : owner index reported while the lock is free
//   idx_width    : bits needed to hold a client index
//   cnt_width    : bits needed for a counter running 0..n_cycles-1
package accel_lock_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWNED = 2'd1,
      RST   = 2'd2
   } lock_state_e;

   // Free lock reports an index one past the last client.
   function automatic logic [31:0] OWNER_NONE(input int unsigned n_clients);
      return 32'(n_clients);
   endfunction

   function automatic int unsigned idx_width(input int unsigned n_clients);
      return (n_clients > 1) ? $clog2(n_clients) : 1;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n_cycles);
      return (n_cycles > 2) ? $clog2(n_cycles) : 1;
   endfunction

endpackage

// File: rtl/accel_lock_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   i_req      : request vector, one bit per client
//   i_last     : index of the most recently served client
//   o_grant_c  : one-hot winner (zero when nothing requested)
//   o_idx_c    : winner index
//   o_valid_c  : at least one request present
// Search starts at (i_last+1) and wraps modulo N, which need not be a power of two.
module rr_pick
   import accel_lock_pkg::*;
#(
   parameter  int unsigned N  = 2,
   localparam int unsigned IW = idx_width(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_last,
   output logic [N-1:0]  o_grant_c,
   output logic [IW-1:0] o_idx_c,
   output logic          o_valid_c
);

   // One extra bit so last+k (at most 2N-1) never overflows before the wrap.
   logic [IW:0] w_cand;

   // First requester found walking upward from the slot after the last owner.
   always_comb begin
      o_grant_c = '0;
      o_idx_c   = '0;
      o_valid_c = 1'b0;
      w_cand    = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         w_cand = (IW+1)'(i_last) + (IW+1)'(k);
         if (w_cand >= (IW+1)'(N)) begin
            w_cand = w_cand - (IW+1)'(N);
         end
         if (!o_valid_c && i_req[w_cand[IW-1:0]]) begin
            o_valid_c                  = 1'b1;
            o_idx_c                    = w_cand[IW-1:0];
            o_grant_c[w_cand[IW-1:0]]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/accel_lock_arbiter.sv
// Round-robin lock that shares one encryption accelerator between cores.
// Optional watchdog reclaim is compiled in with ACCEL_LOCK_WATCHDOG_EN.
//   clk, rst_n         : clock, asynchronous active-low reset
//   req_i              : per-core one-cycle acquire strobe (latched as pending)
//   rel_i              : per-core one-cycle release strobe (owner only)
//   grant_o            : one-hot owner, zero when free
//   owner_o            : owner index, N_CLIENTS when free
//   locked_o           : lock is held
//   accelerator_rst_n  : accelerator reset, pulsed low after every release
//   timeout_o          : one-cycle pulse when the watchdog reclaims the lock
module accel_lock_arbiter
   import accel_lock_pkg::*;
#(
   parameter int unsigned N_CLIENTS        = 2,
   parameter int unsigned TIMEOUT_CYCLES   = 1024,
   parameter int unsigned RST_PULSE_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_CLIENTS-1:0] req_i,
   input  logic [N_CLIENTS-1:0] rel_i,
   output logic [N_CLIENTS-1:0] grant_o,
   output logic [31:0]          owner_o,
   output logic                 locked_o,
   output logic                 accelerator_rst_n,
   output logic                 timeout_o
);

   localparam int unsigned IW = idx_width(N_CLIENTS);
   localparam int unsigned RW = cnt_width(RST_PULSE_CYCLES);

   lock_state_e          r_state, w_state_nxt;
   logic [N_CLIENTS-1:0] r_pending, w_pend_nxt;
   logic [N_CLIENTS-1:0] r_grant, w_grant_nxt;
   logic [31:0]          r_owner, w_owner_nxt;
   logic [IW-1:0]        r_last, w_last_nxt;
   logic                 r_locked, w_locked_nxt;
   logic                 r_acc_rst_n, w_acc_rst_n_nxt;
   logic [RW-1:0]        r_rst_cnt, w_rst_cnt_nxt;
   logic                 w_go_rst;
   logic [N_CLIENTS-1:0] w_req_eff;

   logic [N_CLIENTS-1:0] w_pick_req;
   logic [N_CLIENTS-1:0] w_pick_grant;
   logic [IW-1:0]        w_pick_idx;
   logic                 w_pick_valid;
   logic                 w_grant_evt;
   logic                 w_rel_own;

   // While owned, r_last is the owner index.
   assign w_rel_own   = (r_state == OWNED) && rel_i[r_last];
   assign w_pick_req  = r_pending | req_i;
   assign w_grant_evt = (r_state == IDLE) && w_pick_valid;

   rr_pick #(
      .N (N_CLIENTS)
   ) u_pick (
      .i_req     (w_pick_req),
      .i_last    (r_last),
      .o_grant_c (w_pick_grant),
      .o_idx_c   (w_pick_idx),
      .o_valid_c (w_pick_valid)
   );

`ifdef ACCEL_LOCK_WATCHDOG_EN
   localparam int unsigned WW = cnt_width(TIMEOUT_CYCLES);

   logic [WW-1:0] r_wd_cnt;
   logic          r_timeout, w_timeout_nxt;
   logic          w_wd_expire;

   assign w_wd_expire = (r_wd_cnt == WW'(TIMEOUT_CYCLES - 1));

   // Hold-time counter: zero in the first owned cycle, +1 per owned cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wd_cnt <= '0;
      end else if (w_grant_evt) begin
         r_wd_cnt <= '0;
      end else if (r_state == OWNED) begin
         r_wd_cnt <= r_wd_cnt + WW'(1);
      end
   end

   // Pulse marks the first cycle of the reclaim reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_timeout_nxt;
      end
   end

   assign timeout_o = r_timeout;
`else
   // Watchdog compiled out: lock is held until released, pulse is constant 0.
   assign timeout_o = 1'b0 && (TIMEOUT_CYCLES >= 2);
`endif

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt     = r_state;
      w_grant_nxt     = r_grant;
      w_owner_nxt     = r_owner;
      w_last_nxt      = r_last;
      w_locked_nxt    = r_locked;
      w_acc_rst_n_nxt = 1'b1;
      w_rst_cnt_nxt   = r_rst_cnt;
      w_go_rst        = 1'b0;
`ifdef ACCEL_LOCK_WATCHDOG_EN
      w_timeout_nxt   = 1'b0;
`endif
      // Owner re-requests are dropped unless it is releasing in the same cycle.
      w_req_eff = req_i;
      if ((r_state == OWNED) && !w_rel_own) begin
         w_req_eff[r_last] = 1'b0;
      end
      w_pend_nxt = r_pending | w_req_eff;

      unique case (r_state)
         IDLE: begin
            if (w_grant_evt) begin
               w_state_nxt  = OWNED;
               w_grant_nxt  = w_pick_grant;
               w_owner_nxt  = 32'(w_pick_idx);
               w_last_nxt   = w_pick_idx;
               w_locked_nxt = 1'b1;
               w_pend_nxt   = w_pend_nxt & ~w_pick_grant;
            end
         end
         OWNED: begin
            if (w_rel_own) begin
               w_go_rst = 1'b1;
            end
`ifdef ACCEL_LOCK_WATCHDOG_EN
            else if (w_wd_expire) begin
               w_go_rst      = 1'b1;
               w_timeout_nxt = 1'b1;
            end
`endif
         end
         RST: begin
            w_acc_rst_n_nxt = 1'b0;
            if (r_rst_cnt == RW'(RST_PULSE_CYCLES - 1)) begin
               w_state_nxt     = IDLE;
               w_acc_rst_n_nxt = 1'b1;
            end else begin
               w_rst_cnt_nxt = r_rst_cnt + RW'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      // Release or reclaim: free the lock and start the accelerator reset pulse.
      if (w_go_rst) begin
         w_state_nxt     = RST;
         w_grant_nxt     = '0;
         w_owner_nxt     = OWNER_NONE(N_CLIENTS);
         w_locked_nxt    = 1'b0;
         w_acc_rst_n_nxt = 1'b0;
         w_rst_cnt_nxt   = '0;
      end
   end

   // State and registered outputs; pointer resets so client 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_pending   <= '0;
         r_grant     <= '0;
         r_owner     <= OWNER_NONE(N_CLIENTS);
         r_last      <= IW'(N_CLIENTS - 1);
         r_locked    <= 1'b0;
         r_acc_rst_n <= 1'b0;
         r_rst_cnt   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_pending   <= w_pend_nxt;
         r_grant     <= w_grant_nxt;
         r_owner     <= w_owner_nxt;
         r_last      <= w_last_nxt;
         r_locked    <= w_locked_nxt;
         r_acc_rst_n <= w_acc_rst_n_nxt;
         r_rst_cnt   <= w_rst_cnt_nxt;
      end
   end

   assign grant_o           = r_grant;
   assign owner_o           = r_owner;
   assign locked_o          = r_locked;
   assign accelerator_rst_n = r_acc_rst_n;

endmodule

// File: tb/tb_accel_lock_arbiter.sv
// Bench for accel_lock_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a timeline-based reference of the lock.
// Honours ACCEL_LOCK_WATCHDOG_EN the same way the design does.
module tb_accel_lock_arbiter;

   localparam int unsigned N = 3;
   localparam int unsigned T = 8;
   localparam int unsigned P = 2;
`ifdef ACCEL_LOCK_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req_i;
   logic [N-1:0]  rel_i;
   logic [N-1:0]  grant_o;
   logic [31:0]   owner_o;
   logic          locked_o;
   logic          accelerator_rst_n;
   logic          timeout_o;

   always #5 clk = ~clk;

   accel_lock_arbiter #(
      .N_CLIENTS        (N),
      .TIMEOUT_CYCLES   (T),
      .RST_PULSE_CYCLES (P)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .req_i             (req_i),
      .rel_i             (rel_i),
      .grant_o           (grant_o),
      .owner_o           (owner_o),
      .locked_o          (locked_o),
      .accelerator_rst_n (accelerator_rst_n),
      .timeout_o         (timeout_o)
   );

   int n_checks = 0;
   int n_err    = 0;

   // Reference: owner plus edge-count timestamps for when the accelerator
   // comes out of reset and when the next grant is allowed.
   int       m_owner;
   int       m_last;
   int       m_edge;
   int       m_grant_edge;
   int       m_grant_ok;
   int       m_acc_low_until;
   bit [N-1:0] m_pend;
   bit       m_acc;
   bit       m_timeout;

   function automatic void m_reset();
      m_owner         = -1;
      m_last          = N - 1;
      m_edge          = 0;
      m_grant_edge    = 0;
      m_grant_ok      = 0;
      m_acc_low_until = 0;
      m_pend          = '0;
      m_acc           = 1'b0;
      m_timeout       = 1'b0;
   endfunction

   function automatic void m_clock(input bit [N-1:0] req, input bit [N-1:0] rel);
      int  e;
      bit  released;
      bit  expired;
      e         = m_edge;
      m_timeout = 1'b0;
      if (m_owner >= 0) begin
         released = rel[m_owner];
         expired  = WD && ((e - m_grant_edge) == int'(T));
         for (int i = 0; i < int'(N); i++) begin
            if (req[i] && (i != m_owner || released)) m_pend[i] = 1'b1;
         end
         if (released || expired) begin
            m_timeout       = expired && !released;
            m_owner         = -1;
            m_acc_low_until = e + int'(P);
            m_grant_ok      = e + int'(P) + 1;
         end
      end else begin
         m_pend = m_pend | req;
         if (e >= m_grant_ok && m_pend != '0) begin
            for (int k = 1; k <= int'(N); k++) begin
               int c;
               c = (m_last + k) % int'(N);
               if (m_owner < 0 && m_pend[c]) m_owner = c;
            end
            m_last         = m_owner;
            m_pend[m_owner] = 1'b0;
            m_grant_edge   = e;
         end
      end
      m_acc  = (e >= m_acc_low_until);
      m_edge = m_edge + 1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [31:0] g;
      logic [31:0] o;
      g = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
      o = (m_owner >= 0) ? 32'(m_owner) : 32'(N);
      check({tag, ".grant"},   32'(grant_o), g);
      check({tag, ".owner"},   owner_o, o);
      check({tag, ".locked"},  32'(locked_o), 32'(m_owner >= 0));
      check({tag, ".acc_rst"}, 32'(accelerator_rst_n), 32'(m_acc));
      check({tag, ".timeout"}, 32'(timeout_o), 32'(m_timeout));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".grant"},   32'(grant_o), 32'd0);
      check({tag, ".owner"},   owner_o, 32'(N));
      check({tag, ".locked"},  32'(locked_o), 32'd0);
      check({tag, ".acc_rst"}, 32'(accelerator_rst_n), 32'd0);
      check({tag, ".timeout"}, 32'(timeout_o), 32'd0);
   endtask

   task automatic step(input logic [N-1:0] req, input logic [N-1:0] rel, input string tag);
      @(negedge clk);
      req_i = req;
      rel_i = rel;
      @(posedge clk);
      m_clock(req, rel);
      #1;
      check_model(tag);
   endtask

   // Release whatever is owned and wait until the lock is free with nothing pending.
   task automatic drain();
      for (int i = 0; i < 40; i++) begin
         if (m_owner >= 0) step('0, N'(1) << m_owner, "drain");
         else if (m_pend != '0 || m_edge < m_grant_ok) step('0, '0, "drain");
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req_i = '0;
      rel_i = '0;
      m_reset();
      #12;
      check_reset_vals("por");
      @(negedge clk);
      rst_n = 1'b1;

      // First acquire: client 0 wins from reset pointer.
      step(3'b001, 3'b000, "acq0");
      check("acq0_owner_idx", owner_o, 32'd0);
      // Another core asks while owned: owner unchanged, request kept.
      step(3'b010, 3'b000, "req1_while_owned");
      check("req1_owner_held", owner_o, 32'd0);
      // Release: two reset cycles, one idle cycle, then client 1.
      step(3'b000, 3'b001, "rel0");
      check("rel0_acc_low", 32'(accelerator_rst_n), 32'd0);
      step(3'b000, 3'b000, "rst_c2");
      check("rst_c2_acc_low", 32'(accelerator_rst_n), 32'd0);
      step(3'b000, 3'b000, "idle_gap");
      check("idle_gap_free", owner_o, 32'(N));
      step(3'b000, 3'b000, "grant1");
      check("grant1_owner_idx", owner_o, 32'd1);
      check("grant1_onehot", 32'(grant_o), 32'd2);

      // Release 1 with requests from 0 and 2 during the pulse: 2 comes next, then 0.
      step(3'b101, 3'b010, "rel1_req02");
      repeat (3) step(3'b000, 3'b000, "wait_rr");
      check("rr_next_is_2", owner_o, 32'd2);
      // Non-owner release is ignored.
      step(3'b000, 3'b001, "rel_nonowner");
      check("rel_nonowner_held", owner_o, 32'd2);
      // Owner releases and re-requests in one cycle: release wins, request latched.
      step(3'b100, 3'b100, "rel_req_same");
      repeat (3) step(3'b000, 3'b000, "wait_rr2");
      check("rr_then_0", owner_o, 32'd0);
      step(3'b000, 3'b001, "rel0b");
      repeat (3) step(3'b000, 3'b000, "wait_regrant2");
      check("regrant_2", owner_o, 32'd2);

      // Long hold: watchdog reclaims after T owned cycles, otherwise lock stays.
      drain();
      step(3'b001, 3'b000, "hold_acq");
      for (int i = 1; i <= int'(T); i++) step(3'b000, 3'b000, "hold");
`ifdef ACCEL_LOCK_WATCHDOG_EN
      check("wd_timeout_pulse", 32'(timeout_o), 32'd1);
      check("wd_unlocked", 32'(locked_o), 32'd0);
      step(3'b000, 3'b000, "wd_after");
      check("wd_pulse_one_cycle", 32'(timeout_o), 32'd0);
`else
      repeat (100) step(3'b000, 3'b000, "hold");
      check("hold_no_wd_locked", 32'(locked_o), 32'd1);
      check("hold_no_wd_owner", owner_o, 32'd0);
`endif

      // Reset in the middle of ownership with a pending request.
      drain();
      step(3'b001, 3'b000, "pre_rst_acq");
      step(3'b010, 3'b000, "pre_rst_pend");
      @(negedge clk);
      req_i = '0;
      rel_i = '0;
      #2;
      rst_n = 1'b0;
      m_reset();
      #1;
      check_reset_vals("mid_rst");
      @(posedge clk);
      #1;
      check_reset_vals("rst_held");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step(3'b000, 3'b000, "post_rst_idle");
      check("post_rst_no_grant", 32'(locked_o), 32'd0);
      step(3'b010, 3'b000, "post_rst_req");
      check("post_rst_grant1", owner_o, 32'd1);

      // Random traffic against the reference.
      for (int i = 0; i < 2500; i++) begin
         logic [N-1:0] rq;
         logic [N-1:0] rl;
         for (int b = 0; b < int'(N); b++) begin
            rq[b] = ($urandom_range(3) == 0);
            rl[b] = ($urandom_range(7) == 0);
         end
         step(rq, rl, "rand");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
